// File: rtl/pacman_map_pkg.sv
// rtl/pacman_map_pkg.sv - maze geometry, direction type and wall ROM contents; PACMAN_MAP_TUNNEL_EN opens the side tunnels
package pacman_map_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int MAP_COLS   = 40;
    localparam int MAP_ROWS   = 30;
    localparam int SCR_W      = 640;
    localparam int SCR_H      = 480;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef logic [MAP_ROWS-1:0][MAP_COLS-1:0] map_t;

    function automatic logic in_box(input int c, input int r,
                                    input int c0, input int c1,
                                    input int r0, input int r1);
        return (c >= c0) && (c <= c1) && (r >= r0) && (r <= r1);
    endfunction

    function automatic map_t build_map();
        map_t m;
        m = '0;
        for (int r = 0; r < MAP_ROWS; r++) begin
            for (int c = 0; c < MAP_COLS; c++) begin
                m[r][c] = (r == 0) || (r == MAP_ROWS-1) || (c == 0) || (c == MAP_COLS-1)
                       || in_box(c, r,  4,  9,  4,  5) || in_box(c, r, 30, 35,  4,  5)
                       || in_box(c, r,  4,  9, 24, 25) || in_box(c, r, 30, 35, 24, 25)
                       || in_box(c, r, 19, 20, 20, 25)
                       || (in_box(c, r, 16, 23, 12, 12) && !in_box(c, r, 19, 20, 12, 12))
                       || in_box(c, r, 16, 23, 17, 17)
                       || in_box(c, r, 16, 16, 12, 17) || in_box(c, r, 23, 23, 12, 17);
`ifdef PACMAN_MAP_TUNNEL_EN
                if ((r == 14 || r == 15) && (c == 0 || c == MAP_COLS-1)) begin
                    m[r][c] = 1'b0;
                end
`endif
            end
        end
        return m;
    endfunction

    localparam map_t WALL_MAP = build_map();

endpackage

// File: rtl/pacman_map_rom.sv
// rtl/pacman_map_rom.sv - combinational tile row/col to wall bit lookup
module pacman_map_rom
    import pacman_map_pkg::*;
(
    input  logic [4:0] row,
    input  logic [5:0] col,
    output logic       wall
);

    localparam logic [4:0] ROW_LIM = 5'(MAP_ROWS);
    localparam logic [5:0] COL_LIM = 6'(MAP_COLS);

    // Indices past the map edge cannot occur after the bounds check, but read as wall anyway.
    always_comb begin
        wall = 1'b1;
        if ((row < ROW_LIM) && (col < COL_LIM)) begin
            wall = WALL_MAP[row][col];
        end
    end

endmodule

// File: rtl/pacman_wall_map.sv
// rtl/pacman_wall_map.sv - registered pixel-to-tile wall lookup with bounds check; PACMAN_MAP_TUNNEL_EN via package
module pacman_wall_map
    import pacman_map_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       q_valid,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       isWall,
    output logic       r_valid,
    output logic       oob,
    output logic [5:0] tile_x,
    output logic [4:0] tile_y
);

    localparam logic [9:0] X_LIM = 10'(SCR_W);
    localparam logic [8:0] Y_LIM = 9'(SCR_H);

    logic       is_wall_d, is_wall_q;
    logic       r_valid_d, r_valid_q;
    logic       oob_d, oob_q;
    logic [5:0] tile_x_d, tile_x_q;
    logic [4:0] tile_y_d, tile_y_q;
    logic       rom_wall;
    logic       out_of_bounds;

    pacman_map_rom u_rom (
        .row  (y[8:4]),
        .col  (x[9:4]),
        .wall (rom_wall)
    );

    assign out_of_bounds = (x >= X_LIM) || (y >= Y_LIM);

    // Without a query the result registers hold; only r_valid drops.
    always_comb begin
        is_wall_d = is_wall_q;
        oob_d     = oob_q;
        tile_x_d  = tile_x_q;
        tile_y_d  = tile_y_q;
        r_valid_d = 1'b0;
        if (q_valid) begin
            r_valid_d = 1'b1;
            oob_d     = out_of_bounds;
            if (out_of_bounds) begin
                is_wall_d = 1'b1;
                tile_x_d  = '0;
                tile_y_d  = '0;
            end else begin
                is_wall_d = rom_wall;
                tile_x_d  = x[9:4];
                tile_y_d  = y[8:4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_wall_q <= 1'b1;
            r_valid_q <= 1'b0;
            oob_q     <= 1'b0;
            tile_x_q  <= '0;
            tile_y_q  <= '0;
        end else begin
            is_wall_q <= is_wall_d;
            r_valid_q <= r_valid_d;
            oob_q     <= oob_d;
            tile_x_q  <= tile_x_d;
            tile_y_q  <= tile_y_d;
        end
    end

    assign isWall  = is_wall_q;
    assign r_valid = r_valid_q;
    assign oob     = oob_q;
    assign tile_x  = tile_x_q;
    assign tile_y  = tile_y_q;

endmodule

// File: tb/tb_pacman_wall_map.sv
// tb/tb_pacman_wall_map.sv - directed and random checks of pacman_wall_map against a rectangle-list model
module tb_pacman_wall_map;

    logic       clk;
    logic       rst;
    logic       q_valid;
    logic [9:0] x;
    logic [8:0] y;
    logic       isWall;
    logic       r_valid;
    logic       oob;
    logic [5:0] tile_x;
    logic [4:0] tile_y;

    int checks = 0;
    int passed = 0;

    bit exp_wall = 1'b1;
    bit exp_rv   = 1'b0;
    bit exp_oob  = 1'b0;
    int exp_tx   = 0;
    int exp_ty   = 0;

    pacman_wall_map dut (
        .clk     (clk),
        .rst     (rst),
        .q_valid (q_valid),
        .x       (x),
        .y       (y),
        .isWall  (isWall),
        .r_valid (r_valid),
        .oob     (oob),
        .tile_x  (tile_x),
        .tile_y  (tile_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wall rectangles {c0, c1, r0, r1}, inclusive, in tile units.
    int rects [0:13][0:3] = '{
        '{0, 39, 0, 0}, '{0, 39, 29, 29}, '{0, 0, 0, 29}, '{39, 39, 0, 29},
        '{4, 9, 4, 5}, '{30, 35, 4, 5}, '{4, 9, 24, 25}, '{30, 35, 24, 25},
        '{19, 20, 20, 25},
        '{16, 18, 12, 12}, '{21, 23, 12, 12},
        '{16, 23, 17, 17}, '{16, 16, 12, 17}, '{23, 23, 12, 17}
    };

    function automatic bit model_tile(input int c, input int r);
        bit w = 0;
`ifdef PACMAN_MAP_TUNNEL_EN
        if ((r == 14 || r == 15) && (c == 0 || c == 39)) return 0;
`endif
        for (int i = 0; i < 14; i++) begin
            if (c >= rects[i][0] && c <= rects[i][1] && r >= rects[i][2] && r <= rects[i][3])
                w = 1;
        end
        return w;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d (x=%0d y=%0d)", tag, obs, exp, x, y);
    endtask

    // One clock: drive inputs at the falling edge, update the model, check just after the rising edge.
    task automatic step(input bit r, input bit qv, input int xx, input int yy);
        @(negedge clk);
        rst = r; q_valid = qv; x = 10'(xx); y = 9'(yy);
        @(posedge clk);
        #1;
        if (r) begin
            exp_wall = 1; exp_rv = 0; exp_oob = 0; exp_tx = 0; exp_ty = 0;
        end else if (qv) begin
            exp_rv  = 1;
            exp_oob = (xx >= 640) || (yy >= 480);
            if (exp_oob) begin
                exp_wall = 1; exp_tx = 0; exp_ty = 0;
            end else begin
                exp_tx   = xx / 16;
                exp_ty   = yy / 16;
                exp_wall = model_tile(exp_tx, exp_ty);
            end
        end else begin
            exp_rv = 0;
        end
        chk("isWall",  32'(isWall),  32'(exp_wall));
        chk("r_valid", 32'(r_valid), 32'(exp_rv));
        chk("oob",     32'(oob),     32'(exp_oob));
        chk("tile_x",  32'(tile_x),  exp_tx);
        chk("tile_y",  32'(tile_y),  exp_ty);
    endtask

    initial begin
        rst = 1'b1; q_valid = 1'b0; x = '0; y = '0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        step(0, 1, 16, 16);
        step(0, 1, 64, 64);
        step(0, 1, 640, 0);
        step(0, 1, 1023, 100);
        step(0, 1, 639, 479);
        step(0, 1, 304, 192);
        step(0, 1, 256, 192);
        step(0, 1, 288, 224);

        step(0, 1, 16, 16);
        step(0, 1, 64, 64);
        step(0, 1, 16, 16);
        step(0, 0, 64, 64);
        step(0, 0, 700, 500);

        step(0, 1, 0, 224);
        step(0, 1, 0, 240);
        step(0, 1, 639, 224);
        step(0, 1, 0, 100);
        step(0, 1, 100, 480);
        step(0, 1, 639, 0);

        step(0, 1, 16, 16);
        step(1, 1, 640, 64);
        step(0, 0, 16, 16);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
